// File: rtl/pc_unit.sv
// Program-counter stage: selects PC+4 / PC+imm / (rs1+imm)&~1, halts on a
// misaligned redirect target, and keeps retired/taken instruction counters.
module pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Cnd,
  input  logic             Jal,
  input  logic             Jalr,
  input  logic [31:0]      imm,
  input  logic [31:0]      rs1_data,
  input  logic             stall,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             fetch_valid,
  output logic             halted,
  output logic [31:0]      trap_pc,
  output logic [31:0]      trap_target,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t           state_q;
  logic [31:0]      pc_q;
  logic             fetch_valid_q;
  logic             halted_q;
  logic [31:0]      trap_pc_q;
  logic [31:0]      trap_target_q;
  logic [CNT_W-1:0] retired_q;
  logic [CNT_W-1:0] taken_q;

  logic             redirect;
  logic             misalign;
  logic [31:0]      target_d;

  // Jalr outranks Jal, which outranks Cnd; Jal and Cnd share the PC-relative target.
  always_comb begin
    redirect = Jalr | Jal | Cnd;
    target_d = pc_q + 32'd4;
    if (Jalr)
      target_d = (rs1_data + imm) & 32'hFFFF_FFFE;
    else if (Jal || Cnd)
      target_d = pc_q + imm;
    misalign = redirect && (target_d[1:0] != 2'b00);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      fetch_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      trap_pc_q     <= '0;
      trap_target_q <= '0;
      retired_q     <= '0;
      taken_q       <= '0;
    end else begin
      case (state_q)
        BOOT: begin
          state_q       <= RUN;
          fetch_valid_q <= 1'b1;
        end
        RUN: begin
          if (!stall) begin
            if (misalign) begin
              state_q       <= HALT;
              fetch_valid_q <= 1'b0;
              halted_q      <= 1'b1;
              trap_pc_q     <= pc_q;
              trap_target_q <= target_d;
            end else begin
              pc_q      <= target_d;
              retired_q <= retired_q + CNT_W'(1);
              taken_q   <= taken_q + CNT_W'(redirect);
            end
          end
        end
        HALT: ;
        default: begin
          state_q       <= BOOT;
          fetch_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign fetch_valid = fetch_valid_q;
  assign halted      = halted_q;
  assign trap_pc     = trap_pc_q;
  assign trap_target = trap_target_q;
  assign retired_cnt = retired_q;
  assign taken_cnt   = taken_q;

endmodule
